// File: rtl/dmem_lsu.sv
// Load/store unit for a 512x32 word memory: aligned byte/half/word
// accesses, sub-word stores via read-modify-write, one request in flight.
module dmem_lsu #(
  parameter int DEPTH = 512,
  parameter int IDX_W = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t state, state_nx;

  logic             r_we;
  logic [1:0]       r_size;
  logic             r_uns;
  logic [1:0]       r_lo;
  logic [IDX_W-1:0] idx;
  logic [31:0]      wbuf;

  logic        hs;
  logic        req_err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext;
  logic [31:0] merged;

  assign hs = req_valid & req_ready;

  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)
      req_err = 1'b1;
    if (req_size == 2'b01 && req_addr[0])
      req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
    if (req_addr >= 32'(DEPTH * 4))
      req_err = 1'b1;
  end

  // Lane extraction and merge both work straight off the read port.
  always_comb begin
    lane_b = mem_rdata[8*r_lo +: 8];
    lane_h = mem_rdata[16*r_lo[1] +: 16];
    ext    = mem_rdata;
    merged = mem_rdata;
    unique case (r_size)
      2'b00: begin
        ext = {{24{~r_uns & lane_b[7]}}, lane_b};
        merged[8*r_lo +: 8] = wbuf[7:0];
      end
      2'b01: begin
        ext = {{16{~r_uns & lane_h[15]}}, lane_h};
        merged[16*r_lo[1] +: 16] = wbuf[15:0];
      end
      default: begin
        ext    = mem_rdata;
        merged = mem_rdata;
      end
    endcase
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (hs) begin
          if (req_err)
            state_nx = RESP;
          else if (req_we && req_size == 2'b10)
            state_nx = WR;
          else
            state_nx = RD;
        end
      end
      RD: begin
        mem_read = 1'b1;
        mem_addr = {{(32-IDX_W){1'b0}}, idx};
        state_nx = r_we ? WR : RESP;
      end
      WR: begin
        mem_write = 1'b1;
        mem_addr  = {{(32-IDX_W){1'b0}}, idx};
        mem_wdata = wbuf;
        state_nx  = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_uns      <= 1'b0;
      r_lo       <= 2'b00;
      idx        <= '0;
      wbuf       <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && hs) begin
        r_we       <= req_we;
        r_size     <= req_size;
        r_uns      <= req_unsigned;
        r_lo       <= req_addr[1:0];
        idx        <= req_addr[IDX_W+1:2];
        wbuf       <= req_wdata;
        resp_rdata <= '0;
        resp_err   <= req_err;
      end
      if (state == RD) begin
        if (r_we)
          wbuf <= merged;
        else
          resp_rdata <= ext;
      end
      if (state == RESP && resp_ready) begin
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural 512x32 memory.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [512];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int both_cnt = 0;
  logic [31:0] last_widx = '0;
  logic [31:0] last_wdata = '0;

  int checks = 0;
  int failures = 0;

  dmem_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[8:0]];

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[8:0]] <= mem_wdata;
      wr_cnt     <= wr_cnt + 1;
      last_widx  <= mem_addr;
      last_wdata <= mem_wdata;
    end
    if (mem_read)
      rd_cnt <= rd_cnt + 1;
    if (mem_read && mem_write)
      both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat);
    req_we = we;
    req_size = size;
    req_unsigned = uns;
    req_addr = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = resp_rdata;
    err = resp_err;
    if (resp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] rd;
  logic er;
  int lat;
  int w0, r0;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: word store then word load
    w0 = wr_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("t1_wr_cnt", 32'(wr_cnt - w0), 1);
    chk("t1_widx", last_widx, 4);
    chk("t1_wdata", last_wdata, 32'hDEADBEEF);
    chk("t1_st_lat", 32'(lat), 2);
    chk("t1_st_rdata", rd, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("t1_ld_rdata", rd, 32'hDEADBEEF);
    chk("t1_ld_err", 32'(er), 0);
    chk("t1_ld_lat", 32'(lat), 2);

    // 2: byte store read-modify-write
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, rd, er, lat);
    w0 = wr_cnt;
    r0 = rd_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5, rd, er, lat);
    chk("t2_rd_cnt", 32'(rd_cnt - r0), 1);
    chk("t2_wr_cnt", 32'(wr_cnt - w0), 1);
    chk("t2_widx", last_widx, 4);
    chk("t2_wdata", last_wdata, 32'h1122A544);
    chk("t2_lat", 32'(lat), 3);
    chk("t2_err", 32'(er), 0);

    // 3: sub-word loads with extension
    do_req(1'b1, 2'b10, 1'b0, 32'h04, 32'h8081F0F1, rd, er, lat);
    do_req(1'b0, 2'b00, 1'b0, 32'h07, 32'h0, rd, er, lat);
    chk("t3_lb", rd, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h07, 32'h0, rd, er, lat);
    chk("t3_lbu", rd, 32'h00000080);
    do_req(1'b0, 2'b01, 1'b0, 32'h04, 32'h0, rd, er, lat);
    chk("t3_lh", rd, 32'hFFFFF0F1);
    do_req(1'b0, 2'b01, 1'b1, 32'h06, 32'h0, rd, er, lat);
    chk("t3_lhu", rd, 32'h00008081);
    do_req(1'b0, 2'b00, 1'b1, 32'h05, 32'h0, rd, er, lat);
    chk("t3_lbu1", rd, 32'h000000F0);

    // 4: error cases
    w0 = wr_cnt;
    r0 = rd_cnt;
    do_req(1'b0, 2'b01, 1'b0, 32'h03, 32'h0, rd, er, lat);
    chk("t4_half_err", {rd[30:0], er}, 1);
    chk("t4_half_lat", 32'(lat), 1);
    do_req(1'b1, 2'b10, 1'b0, 32'h06, 32'hFFFFFFFF, rd, er, lat);
    chk("t4_word_err", {rd[30:0], er}, 1);
    chk("t4_word_lat", 32'(lat), 1);
    do_req(1'b0, 2'b11, 1'b0, 32'h08, 32'h0, rd, er, lat);
    chk("t4_size_err", {rd[30:0], er}, 1);
    do_req(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, rd, er, lat);
    chk("t4_range_err", {rd[30:0], er}, 1);
    chk("t4_range_lat", 32'(lat), 1);
    chk("t4_no_mem", 32'((wr_cnt - w0) + (rd_cnt - r0)), 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h7FC, 32'h0, rd, er, lat);
    chk("t4_last_ok", 32'(er), 0);

    // 5: response back-pressure
    resp_ready = 1'b0;
    w0 = wr_cnt;
    r0 = rd_cnt;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("t5_rdata", rd, 32'h1122A544);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        req_we = 1'b1;
        req_size = 2'b10;
        req_addr = 32'h20;
        req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("t5_hold", {resp_valid, req_ready, resp_rdata[29:0]},
          {1'b1, 1'b0, 30'h1122A544});
    end
    chk("t5_traffic", 32'((wr_cnt - w0) + (rd_cnt - r0)), 1);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_idle", {31'd0, req_ready}, 1);
    chk("t5_mem20", mem[8], 0);

    // 6: reset during RD of a sub-word store
    w0 = wr_cnt;
    req_we = 1'b1;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = 32'h12;
    req_wdata = 32'h77;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t6_in_rd", {31'd0, mem_read}, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_out", {resp_valid, mem_read, mem_write, resp_err,
                       28'd0}, 0);
    chk("t6_rst_addr", mem_addr | mem_wdata | resp_rdata, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_ready", {31'd0, req_ready}, 1);
    @(posedge clk); #1;
    chk("t6_no_write", 32'(wr_cnt - w0), 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("t6_load", rd, 32'h1122A544);
    chk("t6_lat", 32'(lat), 2);

    chk("never_both", 32'(both_cnt), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store initiator in front of the word-organised data memory (512 x 32-bit, word-indexed, no byte enables, combinational read).
- Accepts byte-addressed load/store requests from the core over a valid/ready handshake.
- Performs aligned byte, half-word and word accesses; sub-word stores are done by read-modify-write.
- Returns sign- or zero-extended load data, or an error, on a valid/ready response channel.

Parameters:
- DEPTH, 512, memory depth in 32-bit words.
- IDX_W, 9, word-index width (log2 DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/half used for sub-word stores.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal size.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable, one cycle per write.
- mem_addr  out  32  word index, zero-extended from IDX_W.
- mem_wdata  out  32  merged write word.
- mem_rdata  in  32  memory read data, valid in the same cycle as mem_read.

Behaviour:
- FSM states: IDLE, RD, WR, RESP.
- Reset values: state IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- req_ready=1 only in IDLE, so it is 1 out of reset.
- Any rst assertion aborts the current operation and returns to IDLE:
  - no write is issued after rst;
  - a pending response is discarded.
- IDLE, on req_valid & req_ready:
  - latch we, size, unsigned, addr, wdata;
  - set idx = addr[IDX_W+1:2].
- Error checks, in IDLE:
  - size==11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr >= DEPTH*4.
  - Any failure: go to RESP with resp_err=1, resp_rdata=0; no memory access occurs.
- Transitions from IDLE:
  - load or sub-word store: go to RD;
  - word store: go to WR with mem_wdata = wdata.
- RD (exactly one cycle):
  - mem_read=1, mem_addr=idx; register mem_rdata into a word buffer.
  - Load: extract the lane and go to RESP.
  - Sub-word store: merge and go to WR.
- Lane rules (little-endian):
  - byte lane k = addr[1:0] occupies bits [8k+7:8k];
  - half lane h = addr[1] occupies bits [16h+15:16h].
- Load extension:
  - req_unsigned=1: zero-extend;
  - req_unsigned=0: replicate the lane MSB;
  - word loads are passed through unchanged.
- Store merge: replace only the addressed lane of the buffered word with wdata[7:0] or wdata[15:0]; all other bits are preserved.
- WR (exactly one cycle): mem_write=1, mem_addr=idx, mem_wdata=merged word; then go to RESP.
- mem_read and mem_write are never both 1. Both are 0 in IDLE and RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_ready.
  - On resp_valid & resp_ready: go to IDLE and clear resp_valid.
- Latency, counted from the request handshake edge to the first cycle resp_valid=1:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Throughput: one request in flight. A new request can be accepted in the cycle after the response handshake.
- Back-pressure: resp_ready held low keeps the block in RESP indefinitely with no further memory traffic.
- req_* inputs are ignored outside IDLE.

Test Plan:
1. Reset, then word store addr 0x10 data 0xDEADBEEF, then word load 0x10 -> one mem_write at idx 4; resp_rdata=0xDEADBEEF, resp_err=0; load response 2 cycles after handshake.
2. Byte store addr 0x11 data 0x000000A5 over word 0x11223344 at idx 4 -> RD then WR with mem_wdata=0x1122A544; response 3 cycles after handshake.
3. Loads of the word 0x8081F0F1 at idx 1:
   - byte signed at 0x07 -> 0xFFFFFF80;
   - byte unsigned at 0x07 -> 0x00000080;
   - half signed at 0x04 -> 0xFFFFF0F1;
   - half unsigned at 0x06 -> 0x00008081.
4. Half load at 0x03, word store at 0x06, size 11, and addr 0x800 -> resp_err=1, resp_rdata=0, mem_read=0 and mem_write=0 throughout, response 1 cycle after handshake.
5. Load with resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0; a req_valid pulse during this time is ignored.
6. Assert rst during the RD of a sub-word store -> no mem_write issued, all outputs at reset values, req_ready=1 after rst deasserts; the next load completes normally.
